// File: rtl/axi_master_connector_reg_if.sv
// ---------------------------------------------------------------------------
// axi_master_connector_reg_if
//
// Flat AXI4 master-port bundle (m_axi_*). Used by axi_master_connector_reg to
// drive an external AXI4 slave.
//
// Modports:
//   master : drives AW/W/AR payload + valid and B/R ready; samples the rest.
//   slave  : the mirror image, for the external slave (or a testbench).
//
// Handshake rule on every channel: a beat transfers on a rising clock edge
// where valid and ready are both 1. Once valid is raised it stays high and
// the payload stays constant until that transfer happens.
// ---------------------------------------------------------------------------
interface axi_master_connector_reg_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int ID_WIDTH     = 8,
    parameter int AWUSER_WIDTH = 1,
    parameter int WUSER_WIDTH  = 1,
    parameter int BUSER_WIDTH  = 1,
    parameter int ARUSER_WIDTH = 1,
    parameter int RUSER_WIDTH  = 1
) ();
    // AW channel
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic [3:0]              awregion;
    logic [AWUSER_WIDTH-1:0] awuser;
    logic                    awvalid;
    logic                    awready;
    // W channel
    logic [DATA_WIDTH-1:0]   wdata;
    logic [STRB_WIDTH-1:0]   wstrb;
    logic                    wlast;
    logic [WUSER_WIDTH-1:0]  wuser;
    logic                    wvalid;
    logic                    wready;
    // B channel
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic [BUSER_WIDTH-1:0]  buser;
    logic                    bvalid;
    logic                    bready;
    // AR channel
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic [3:0]              arregion;
    logic [ARUSER_WIDTH-1:0] aruser;
    logic                    arvalid;
    logic                    arready;
    // R channel
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic [RUSER_WIDTH-1:0]  ruser;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awqos, awregion, awuser, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wuser, wvalid,
        input  wready,
        input  bid, bresp, buser, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arqos, arregion, aruser, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, ruser, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awqos, awregion, awuser, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wuser, wvalid,
        output wready,
        output bid, bresp, buser, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arqos, arregion, aruser, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, ruser, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_master_connector_reg.sv
// ---------------------------------------------------------------------------
// axi_master_connector_reg
//
// Converts an (axi_req_t, axi_rsp_t) struct pair into a flat AXI4 master
// port. Every channel goes through a 2-entry skid buffer so all outgoing
// valid, payload and ready signals come straight from flops.
//
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   axi_req_i     : upstream request struct (AW/W/AR payload+valid, B/R ready)
//   axi_rsp_o     : upstream response struct (B/R payload+valid, AW/W/AR ready)
//   m_axi         : flat AXI4 master port (axi_master_connector_reg_if.master)
//   err_cnt_clr_i : error-counter clear      (only with AXI_MASTER_CONN_ERR_CNT_EN)
//   err_cnt_o     : saturating 16-bit count of B/R beats with resp[1]=1
//                                            (only with AXI_MASTER_CONN_ERR_CNT_EN)
//
// Optional feature macro: AXI_MASTER_CONN_ERR_CNT_EN
//
// Handshake rule (both sides): a beat moves on a clock edge where valid and
// ready are both 1; valid/payload hold until then. aw.atop is not forwarded.
// Each skid buffer's FSM state is the state_q signal inside its instance.
// ---------------------------------------------------------------------------

// Two-entry skid buffer. EMPTY -> ONE -> FULL; ready is registered and is
// simply "not FULL next cycle", so in FULL nothing can be captured.
module axi_master_connector_reg_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             ready_q, ready_d;
    logic             in_hs, out_hs;

    assign out_valid_o = (state_q != EMPTY);
    assign out_data_o  = main_q;
    assign in_ready_o  = ready_q;
    assign in_hs       = in_valid_i & ready_q;
    assign out_hs      = out_valid_o & out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_hs) begin
                    state_d = ONE;
                    main_d  = in_data_i;
                end
            end
            ONE: begin
                if (in_hs && !out_hs) begin
                    state_d = FULL;
                    skid_d  = in_data_i;
                end else if (in_hs && out_hs) begin
                    main_d  = in_data_i;
                end else if (out_hs) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_hs) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
        end
    end
endmodule

module axi_master_connector_reg #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int ID_WIDTH     = 8,
    parameter int AWUSER_WIDTH = 1,
    parameter int WUSER_WIDTH  = 1,
    parameter int BUSER_WIDTH  = 1,
    parameter int ARUSER_WIDTH = 1,
    parameter int RUSER_WIDTH  = 1,
    parameter type axi_req_t = struct packed {
        struct packed {
            logic [ID_WIDTH-1:0] id; logic [ADDR_WIDTH-1:0] addr; logic [7:0] len;
            logic [2:0] size; logic [1:0] burst; logic lock; logic [3:0] cache;
            logic [2:0] prot; logic [3:0] qos; logic [3:0] region; logic [5:0] atop;
            logic [AWUSER_WIDTH-1:0] user;
        } aw;
        struct packed {
            logic [DATA_WIDTH-1:0] data; logic [STRB_WIDTH-1:0] strb; logic last;
            logic [WUSER_WIDTH-1:0] user;
        } w;
        struct packed {
            logic [ID_WIDTH-1:0] id; logic [ADDR_WIDTH-1:0] addr; logic [7:0] len;
            logic [2:0] size; logic [1:0] burst; logic lock; logic [3:0] cache;
            logic [2:0] prot; logic [3:0] qos; logic [3:0] region;
            logic [ARUSER_WIDTH-1:0] user;
        } ar;
        logic aw_valid; logic w_valid; logic ar_valid; logic b_ready; logic r_ready;
    },
    parameter type axi_rsp_t = struct packed {
        struct packed {
            logic [ID_WIDTH-1:0] id; logic [1:0] resp; logic [BUSER_WIDTH-1:0] user;
        } b;
        struct packed {
            logic [ID_WIDTH-1:0] id; logic [DATA_WIDTH-1:0] data; logic [1:0] resp;
            logic last; logic [RUSER_WIDTH-1:0] user;
        } r;
        logic aw_ready; logic w_ready; logic ar_ready; logic b_valid; logic r_valid;
    }
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  axi_req_t axi_req_i,
    output axi_rsp_t axi_rsp_o,
    axi_master_connector_reg_if.master m_axi
`ifdef AXI_MASTER_CONN_ERR_CNT_EN
    ,
    input  logic        err_cnt_clr_i,
    output logic [15:0] err_cnt_o
`endif
);
    localparam int AW_W = ID_WIDTH + ADDR_WIDTH + 29 + AWUSER_WIDTH;
    localparam int W_W  = DATA_WIDTH + STRB_WIDTH + 1 + WUSER_WIDTH;
    localparam int B_W  = ID_WIDTH + 2 + BUSER_WIDTH;
    localparam int AR_W = ID_WIDTH + ADDR_WIDTH + 29 + ARUSER_WIDTH;
    localparam int R_W  = ID_WIDTH + DATA_WIDTH + 3 + RUSER_WIDTH;

    logic [AW_W-1:0] aw_out;
    logic [W_W-1:0]  w_out;
    logic [B_W-1:0]  b_out;
    logic [AR_W-1:0] ar_out;
    logic [R_W-1:0]  r_out;

    // Atomic operations are not supported downstream; atop is dropped here.
    logic [5:0] unused_atop;
    assign unused_atop = axi_req_i.aw.atop;

    axi_master_connector_reg_skid #(.WIDTH(AW_W)) u_aw_skid (
        .clk_i, .rst_i,
        .in_valid_i  (axi_req_i.aw_valid),
        .in_ready_o  (axi_rsp_o.aw_ready),
        .in_data_i   ({axi_req_i.aw.id, axi_req_i.aw.addr, axi_req_i.aw.len,
                       axi_req_i.aw.size, axi_req_i.aw.burst, axi_req_i.aw.lock,
                       axi_req_i.aw.cache, axi_req_i.aw.prot, axi_req_i.aw.qos,
                       axi_req_i.aw.region, axi_req_i.aw.user}),
        .out_valid_o (m_axi.awvalid),
        .out_ready_i (m_axi.awready),
        .out_data_o  (aw_out)
    );
    assign {m_axi.awid, m_axi.awaddr, m_axi.awlen, m_axi.awsize, m_axi.awburst,
            m_axi.awlock, m_axi.awcache, m_axi.awprot, m_axi.awqos,
            m_axi.awregion, m_axi.awuser} = aw_out;

    axi_master_connector_reg_skid #(.WIDTH(W_W)) u_w_skid (
        .clk_i, .rst_i,
        .in_valid_i  (axi_req_i.w_valid),
        .in_ready_o  (axi_rsp_o.w_ready),
        .in_data_i   ({axi_req_i.w.data, axi_req_i.w.strb, axi_req_i.w.last,
                       axi_req_i.w.user}),
        .out_valid_o (m_axi.wvalid),
        .out_ready_i (m_axi.wready),
        .out_data_o  (w_out)
    );
    assign {m_axi.wdata, m_axi.wstrb, m_axi.wlast, m_axi.wuser} = w_out;

    axi_master_connector_reg_skid #(.WIDTH(AR_W)) u_ar_skid (
        .clk_i, .rst_i,
        .in_valid_i  (axi_req_i.ar_valid),
        .in_ready_o  (axi_rsp_o.ar_ready),
        .in_data_i   ({axi_req_i.ar.id, axi_req_i.ar.addr, axi_req_i.ar.len,
                       axi_req_i.ar.size, axi_req_i.ar.burst, axi_req_i.ar.lock,
                       axi_req_i.ar.cache, axi_req_i.ar.prot, axi_req_i.ar.qos,
                       axi_req_i.ar.region, axi_req_i.ar.user}),
        .out_valid_o (m_axi.arvalid),
        .out_ready_i (m_axi.arready),
        .out_data_o  (ar_out)
    );
    assign {m_axi.arid, m_axi.araddr, m_axi.arlen, m_axi.arsize, m_axi.arburst,
            m_axi.arlock, m_axi.arcache, m_axi.arprot, m_axi.arqos,
            m_axi.arregion, m_axi.aruser} = ar_out;

    axi_master_connector_reg_skid #(.WIDTH(B_W)) u_b_skid (
        .clk_i, .rst_i,
        .in_valid_i  (m_axi.bvalid),
        .in_ready_o  (m_axi.bready),
        .in_data_i   ({m_axi.bid, m_axi.bresp, m_axi.buser}),
        .out_valid_o (axi_rsp_o.b_valid),
        .out_ready_i (axi_req_i.b_ready),
        .out_data_o  (b_out)
    );
    assign {axi_rsp_o.b.id, axi_rsp_o.b.resp, axi_rsp_o.b.user} = b_out;

    axi_master_connector_reg_skid #(.WIDTH(R_W)) u_r_skid (
        .clk_i, .rst_i,
        .in_valid_i  (m_axi.rvalid),
        .in_ready_o  (m_axi.rready),
        .in_data_i   ({m_axi.rid, m_axi.rdata, m_axi.rresp, m_axi.rlast, m_axi.ruser}),
        .out_valid_o (axi_rsp_o.r_valid),
        .out_ready_i (axi_req_i.r_ready),
        .out_data_o  (r_out)
    );
    assign {axi_rsp_o.r.id, axi_rsp_o.r.data, axi_rsp_o.r.resp, axi_rsp_o.r.last,
            axi_rsp_o.r.user} = r_out;

`ifdef AXI_MASTER_CONN_ERR_CNT_EN
    // Counts SLVERR/DECERR beats as they enter from the slave side.
    logic        b_err, r_err;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [16:0] err_sum;

    assign b_err = m_axi.bvalid & m_axi.bready & m_axi.bresp[1];
    assign r_err = m_axi.rvalid & m_axi.rready & m_axi.rresp[1];

    always_comb begin
        err_sum   = {1'b0, err_cnt_q} + {16'd0, b_err} + {16'd0, r_err};
        err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        if (err_cnt_clr_i) begin
            err_cnt_d = 16'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_cnt_q <= 16'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;
`endif
endmodule
